// File: rtl/reg_bank_arbiter.sv
// Purpose : two-requester round-robin arbiter giving single-register access to a tick-gated register bank.
// Latency : 2 Tick cycles per access (IDLE grant + XFER); 2 Tick cycles per bank clear (IDLE + CLR).
// Backpress: requesters hold Req/ClearReq until Done/ClearDone; nothing advances on cycles with Tick=0.
//
// Ports:
//   Clock, Reset (async, active-low), Tick (clock enable for the FSM)
//   Req[1:0], Wr[1:0], Addr0/1, WData0/1 : requester 0 (recognition) and 1 (display/readout)
//   ClearReq / ClearDone                  : bank-wide clear handshake, priority over Req
//   Gnt, Done, Err                        : registered one-hot grant, completion and bad-address pulses
//   RegWe, RegCs, RegClr, BusD            : register bank controls (ClockEnable, output disable, reset, D)
//   Busy                                  : arbiter is not idle
module reg_bank_arbiter #(
   parameter int NrOfRegs = 8,
   parameter int AddrBits = 3,
   parameter int NrOfBits = 8
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Tick,
   input  logic [1:0]          Req,
   input  logic [1:0]          Wr,
   input  logic [AddrBits-1:0] Addr0,
   input  logic [AddrBits-1:0] Addr1,
   input  logic [NrOfBits-1:0] WData0,
   input  logic [NrOfBits-1:0] WData1,
   input  logic                ClearReq,
   output logic [1:0]          Gnt,
   output logic [1:0]          Done,
   output logic                Err,
   output logic                ClearDone,
   output logic [NrOfRegs-1:0] RegWe,
   output logic [NrOfRegs-1:0] RegCs,
   output logic                RegClr,
   output logic [NrOfBits-1:0] BusD,
   output logic                Busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      CLR  = 2'd2
   } state_t;

   // Register count widened by one bit so the address bound compare is width-matched.
   localparam logic [AddrBits:0] reg_lim = (AddrBits+1)'(NrOfRegs);

   state_t                state, state_nxt;
   logic [1:0]            gnt_nxt;
   logic                  last, last_nxt;      // requester served most recently
   logic [AddrBits-1:0]   addr_q, addr_nxt;
   logic                  wr_q, wr_nxt;
   logic [NrOfBits-1:0]   wdata_q, wdata_nxt;
   logic                  win;                 // requester that would be granted this cycle
   logic                  addr_ok;
   logic [NrOfRegs-1:0]   sel;

   // On a tie the requester not served last wins; otherwise the lone requester wins.
   always_comb begin
      win = (Req == 2'b11) ? ~last : ~Req[0];
   end

   always_comb begin
      addr_ok = ({1'b0, addr_q} < reg_lim);
      sel     = '0;
      for (int i = 0; i < NrOfRegs; i++) begin
         sel[i] = (addr_q == AddrBits'(i));
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         Gnt     <= 2'b00;
         last    <= 1'b1;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state   <= state_nxt;
         Gnt     <= gnt_nxt;
         last    <= last_nxt;
         addr_q  <= addr_nxt;
         wr_q    <= wr_nxt;
         wdata_q <= wdata_nxt;
      end
   end

   // Next-state and output decode. Bank controls depend only on registered
   // state and the latched request, never on the live Req/Addr inputs.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = Gnt;
      last_nxt  = last;
      addr_nxt  = addr_q;
      wr_nxt    = wr_q;
      wdata_nxt = wdata_q;

      Done      = 2'b00;
      Err       = 1'b0;
      ClearDone = 1'b0;
      RegWe     = '0;
      RegCs     = '1;
      RegClr    = 1'b0;
      BusD      = '0;
      Busy      = (state != IDLE);

      case (state)
         IDLE: begin
            if (Tick) begin
               if (ClearReq) begin
                  state_nxt = CLR;
               end else if (Req != 2'b00) begin
                  state_nxt = XFER;
                  gnt_nxt   = win ? 2'b10 : 2'b01;
                  addr_nxt  = win ? Addr1 : Addr0;
                  wr_nxt    = Wr[win];
                  wdata_nxt = win ? WData1 : WData0;
               end
            end
         end

         XFER: begin
            if (addr_ok) begin
               if (wr_q) begin
                  RegWe = sel;
                  BusD  = wdata_q;
               end else begin
                  RegCs = ~sel;
               end
            end
            Done = Tick ? Gnt : 2'b00;
            Err  = Tick & ~addr_ok;
            if (Tick) begin
               state_nxt = IDLE;
               gnt_nxt   = 2'b00;
               last_nxt  = Gnt[1];
            end
         end

         CLR: begin
            RegClr    = 1'b1;
            ClearDone = Tick;
            if (Tick) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 2'b00;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Purpose : bench for reg_bank_arbiter with a behavioural register bank and a transaction-level reference.
// Latency : reference predicts every output each cycle; directed scenarios plus a randomized phase.
// Backpress: bench requesters hold Req/ClearReq until the reference reports completion.
module tb_reg_bank_arbiter;

   localparam int NREG = 6;
   localparam int AB   = 3;
   localparam int NB   = 8;

   logic            Clock = 1'b0;
   logic            Reset;
   logic            Tick;
   logic [1:0]      Req;
   logic [1:0]      Wr;
   logic [AB-1:0]   Addr0, Addr1;
   logic [NB-1:0]   WData0, WData1;
   logic            ClearReq;
   logic [1:0]      Gnt, Done;
   logic            Err, ClearDone;
   logic [NREG-1:0] RegWe, RegCs;
   logic            RegClr;
   logic [NB-1:0]   BusD;
   logic            Busy;

   reg_bank_arbiter #(.NrOfRegs(NREG), .AddrBits(AB), .NrOfBits(NB)) dut (
      .Clock(Clock), .Reset(Reset), .Tick(Tick), .Req(Req), .Wr(Wr),
      .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
      .ClearReq(ClearReq), .Gnt(Gnt), .Done(Done), .Err(Err), .ClearDone(ClearDone),
      .RegWe(RegWe), .RegCs(RegCs), .RegClr(RegClr), .BusD(BusD), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   int n_chk;
   int n_pass;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
   endtask

   // ---------------- behavioural register bank ----------------
   logic [NB-1:0] bank [NREG];
   logic [NB-1:0] rd_bus;

   always @(posedge Clock or posedge RegClr) begin
      if (RegClr) begin
         for (int i = 0; i < NREG; i++) bank[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) if (Tick && RegWe[i]) bank[i] <= BusD;
      end
   end

   always_comb begin
      rd_bus = '0;
      for (int i = 0; i < NREG; i++) if (!RegCs[i]) rd_bus = bank[i];
   end

   // ---------------- reference model ----------------
   // m_cur: -1 idle, 0/1 = transfer for that requester, 2 = clearing.
   int            m_cur;
   int            m_ptr;
   int            m_addr;
   logic          m_wr;
   logic [NB-1:0] m_wd;
   logic [NB-1:0] m_reg [NREG];
   int            ev_cnt [3];   // completed accesses per requester, completed clears

   function automatic int pick(input logic [1:0] r, input int last_served);
      if (r == 2'b11) return 1 - last_served;
      return r[0] ? 0 : 1;
   endfunction

   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         m_cur <= -1;
         m_ptr <= 1;
      end else if (Tick) begin
         if (m_cur == -1) begin
            if (ClearReq) begin
               m_cur <= 2;
            end else if (Req != 2'b00) begin
               m_cur  <= pick(Req, m_ptr);
               m_addr <= (pick(Req, m_ptr) == 1) ? int'(Addr1) : int'(Addr0);
               m_wr   <= Wr[pick(Req, m_ptr)];
               m_wd   <= (pick(Req, m_ptr) == 1) ? WData1 : WData0;
            end
         end else if (m_cur == 2) begin
            for (int k = 0; k < NREG; k++) m_reg[k] <= '0;
            ev_cnt[2] <= ev_cnt[2] + 1;
            m_cur <= -1;
         end else begin
            if (m_wr && m_addr < NREG) m_reg[m_addr] <= m_wd;
            m_ptr <= m_cur;
            ev_cnt[m_cur] <= ev_cnt[m_cur] + 1;
            m_cur <= -1;
         end
      end
   end

   logic [1:0]      e_gnt, e_done;
   logic            e_err, e_cdone, e_clr, e_busy, e_rd;
   logic [NREG-1:0] e_we, e_cs;
   logic [NB-1:0]   e_bus;

   always_comb begin
      e_gnt = 2'b00; e_done = 2'b00; e_err = 1'b0; e_cdone = 1'b0; e_clr = 1'b0;
      e_we = '0; e_cs = '1; e_bus = '0; e_rd = 1'b0;
      e_busy = (m_cur != -1);
      if (m_cur == 0 || m_cur == 1) begin
         e_gnt = (m_cur == 0) ? 2'b01 : 2'b10;
         if (m_addr < NREG) begin
            if (m_wr) begin
               e_we[m_addr] = 1'b1;
               e_bus = m_wd;
            end else begin
               e_cs[m_addr] = 1'b0;
               e_rd = 1'b1;
            end
         end
         e_done = Tick ? e_gnt : 2'b00;
         e_err  = Tick && !(m_addr < NREG);
      end
      if (m_cur == 2) begin
         e_clr   = 1'b1;
         e_cdone = Tick;
      end
   end

   // Every-cycle comparison of all outputs against the reference, away from the active edge.
   always @(negedge Clock) begin
      check_eq("gnt",    32'(Gnt),       32'(e_gnt));
      check_eq("done",   32'(Done),      32'(e_done));
      check_eq("err",    32'(Err),       32'(e_err));
      check_eq("cdone",  32'(ClearDone), 32'(e_cdone));
      check_eq("regwe",  32'(RegWe),     32'(e_we));
      check_eq("regcs",  32'(RegCs),     32'(e_cs));
      check_eq("regclr", 32'(RegClr),    32'(e_clr));
      check_eq("busd",   32'(BusD),      32'(e_bus));
      check_eq("busy",   32'(Busy),      32'(e_busy));
      if (e_rd) check_eq("rdata", 32'(rd_bus), 32'(m_reg[m_addr]));
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic t);
      @(posedge Clock);
      #1;
      Tick = t;
   endtask

   task automatic wait_evt(input int which, input int budget);
      int start;
      int n;
      start = ev_cnt[which];
      n = 0;
      while (ev_cnt[which] == start && n < budget) begin
         step(1'b1);
         n++;
      end
      check_eq("evt_wait", 32'(ev_cnt[which] - start), 1);
   endtask

   task automatic new_req(input int i);
      Wr[i] = 1'($urandom_range(0, 1));
      if (i == 0) begin
         Addr0  = AB'($urandom_range(0, 7));
         WData0 = NB'($urandom);
      end else begin
         Addr1  = AB'($urandom_range(0, 7));
         WData1 = NB'($urandom);
      end
      Req[i] = 1'b1;
   endtask

   initial begin
      int d0;
      int seen [3];
      n_chk = 0; n_pass = 0;
      Reset = 1'b0; Tick = 1'b0; Req = 2'b00; Wr = 2'b00; ClearReq = 1'b0;
      Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;

      repeat (2) @(posedge Clock);
      #1;
      check_eq("rst_gnt",  32'(Gnt),   0);
      check_eq("rst_we",   32'(RegWe), 0);
      check_eq("rst_cs",   32'(RegCs), 32'h3F);
      check_eq("rst_busy", 32'(Busy),  0);
      check_eq("rst_bus",  32'(BusD),  0);
      Reset = 1'b1;
      Tick  = 1'b1;

      // Bring the bank to a known state.
      ClearReq = 1'b1;
      wait_evt(2, 10);
      ClearReq = 1'b0;

      // Write 0xA7 to reg 5 from requester 0, then read it back from requester 1.
      Req = 2'b01; Wr = 2'b01; Addr0 = 3'd5; WData0 = 8'hA7;
      step(1'b1);
      check_eq("w_gnt",  32'(Gnt),   1);
      check_eq("w_we",   32'(RegWe), 32'h20);
      check_eq("w_bus",  32'(BusD),  32'hA7);
      check_eq("w_done", 32'(Done),  1);
      step(1'b1);
      Req = 2'b10; Wr = 2'b00; Addr1 = 3'd5;
      step(1'b1);
      check_eq("r_cs",   32'(RegCs),  32'h1F);
      check_eq("r_data", 32'(rd_bus), 32'hA7);
      check_eq("r_done", 32'(Done),   2);
      step(1'b1);
      Req = 2'b00;

      // Reset in the middle of a pending write to reg 3.
      Req = 2'b01; Wr = 2'b01; Addr0 = 3'd3; WData0 = 8'h3C;
      step(1'b1);
      check_eq("mid_we_pre", 32'(RegWe), 32'h08);
      #2;
      Reset = 1'b0;
      #1;
      check_eq("mid_we",   32'(RegWe), 0);
      check_eq("mid_cs",   32'(RegCs), 32'h3F);
      check_eq("mid_gnt",  32'(Gnt),   0);
      check_eq("mid_busy", 32'(Busy),  0);
      @(posedge Clock);
      #1;
      Reset = 1'b1; Req = 2'b00;
      Req = 2'b10; Wr = 2'b00; Addr1 = 3'd3;
      step(1'b1);
      check_eq("mid_reg3", 32'(rd_bus), 0);
      step(1'b1);
      Req = 2'b00;

      // Continuous contention: grants alternate starting with requester 0.
      Req = 2'b11; Wr = 2'b11; Addr0 = 3'd1; Addr1 = 3'd2; WData0 = 8'h11; WData1 = 8'h22;
      for (int k = 0; k < 4; k++) begin
         step(1'b1);
         check_eq("alt_gnt", 32'(Gnt), (k % 2 == 0) ? 1 : 2);
         step(1'b1);
      end
      Req = 2'b00;

      // Slow Tick: read reg 2 with Tick every third cycle.
      Req = 2'b10; Wr = 2'b00; Addr1 = 3'd2;
      d0 = ev_cnt[1];
      for (int c = 0; c < 9; c++) begin
         step(c % 3 == 0);
         if (ev_cnt[1] != d0) Req = 2'b00;
         if (m_cur == 1 && !Tick) begin
            check_eq("slow_cs",   32'(RegCs), 32'h3B);
            check_eq("slow_done", 32'(Done),  0);
         end
      end
      check_eq("slow_cnt", 32'(ev_cnt[1] - d0), 1);
      Tick = 1'b1;

      // Clear and request together: clear wins, then requester 0 is served.
      ClearReq = 1'b1; Req = 2'b01; Wr = 2'b01; Addr0 = 3'd1; WData0 = 8'h55;
      step(1'b1);
      check_eq("cq_clr",   32'(RegClr),    1);
      check_eq("cq_cdone", 32'(ClearDone), 1);
      check_eq("cq_gnt",   32'(Gnt),       0);
      step(1'b1);
      ClearReq = 1'b0;
      step(1'b1);
      check_eq("cq_gnt2", 32'(Gnt),   1);
      check_eq("cq_we",   32'(RegWe), 32'h02);
      step(1'b1);
      Req = 2'b00;

      // Out-of-range address.
      Req = 2'b01; Wr = 2'b01; Addr0 = 3'd6; WData0 = 8'hFF;
      step(1'b1);
      check_eq("oor_done", 32'(Done),  1);
      check_eq("oor_err",  32'(Err),   1);
      check_eq("oor_we",   32'(RegWe), 0);
      check_eq("oor_cs",   32'(RegCs), 32'h3F);
      check_eq("oor_bus",  32'(BusD),  0);
      step(1'b1);
      Req = 2'b00;

      // Randomized traffic against the reference.
      for (int k = 0; k < 3; k++) seen[k] = ev_cnt[k];
      for (int n = 0; n < 4000; n++) begin
         step($urandom_range(0, 3) != 0);
         for (int i = 0; i < 2; i++) begin
            if (Req[i]) begin
               if (ev_cnt[i] != seen[i]) begin
                  seen[i] = ev_cnt[i];
                  if ($urandom_range(0, 3) == 0) new_req(i);
                  else Req[i] = 1'b0;
               end
            end else if ($urandom_range(0, 4) == 0) begin
               new_req(i);
            end
         end
         if (ClearReq) begin
            if (ev_cnt[2] != seen[2]) begin
               seen[2] = ev_cnt[2];
               ClearReq = 1'b0;
            end
         end else if ($urandom_range(0, 40) == 0) begin
            ClearReq = 1'b1;
         end
      end
      Req = 2'b00; ClearReq = 1'b0; Tick = 1'b1;
      repeat (4) @(posedge Clock);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Arbitrates two requesters for single-register access to a shared bank of NrOfRegs tick-gated registers on one tri-state bus.
- The two requesters are the recognition datapath (port 0) and the display/readout path (port 1).
- Generates per-register write enables, per-register output-disable (cs) lines, write data and a bank-wide clear strobe.
- Sits between the requesters and the register bank. Register D inputs tie to BusD, ClockEnable to RegWe[i], cs to RegCs[i], Tick to Tick.

Parameters:
NrOfRegs, 8, number of registers in the bank (2..16)
AddrBits, 3, address width; 2**AddrBits >= NrOfRegs
NrOfBits, 8, register/data width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
Tick  in  1  clock-enable pulse; FSM advances only on cycles with Tick=1
Req  in  2  access request per requester; held until matching Done
Wr  in  2  1 = write, 0 = read, per requester; stable while Req
Addr0  in  AddrBits  register address, requester 0
Addr1  in  AddrBits  register address, requester 1
WData0  in  NrOfBits  write data, requester 0
WData1  in  NrOfBits  write data, requester 1
ClearReq  in  1  request bank-wide clear; held until ClearDone
Gnt  out  2  one-hot grant, registered
Done  out  2  one-cycle completion pulse per requester
Err  out  1  one-cycle pulse with Done when granted Addr >= NrOfRegs
ClearDone  out  1  one-cycle pulse when clear completes
RegWe  out  NrOfRegs  one-hot write strobe to register ClockEnable
RegCs  out  NrOfRegs  output disable per register; 1 = high-Z; at most one bit 0
RegClr  out  1  bank clear, drives register Reset inputs
BusD  out  NrOfBits  write data to register D inputs
Busy  out  1  1 whenever state != IDLE

Behaviour:
- States: IDLE, XFER, CLR. Transitions occur only on rising Clock edges with Tick=1. With Tick=0, state, Gnt, the latched address and the latched Wr all hold.
- Reset (Reset=0, async, also valid mid-operation):
  - state=IDLE, Gnt=0, Done=0, Err=0, ClearDone=0.
  - RegWe=0, RegCs=all ones, RegClr=0, BusD=0, Busy=0.
  - Round-robin pointer = 1, so requester 0 wins the first tie.
  - No partial write may occur during reset.
- IDLE:
  - If ClearReq=1, go to CLR. Clear has priority over Req.
  - Else if Req != 0, grant one requester. A single requester wins directly. If both request, the winner is the one not served last.
  - The grant latches Gnt, Addr, Wr and WData of the winner, then goes to XFER.
  - A Req withdrawn before grant is ignored; no side effects.
- XFER (exactly one Tick-qualified cycle; outputs are decoded from the latched grant):
  - Write, Addr < NrOfRegs: RegWe[Addr]=1 and BusD=latched WData. The register loads on the Tick edge.
  - Read, Addr < NrOfRegs: RegCs[Addr]=0. The requester samples the bus in this cycle.
  - Addr >= NrOfRegs: no RegWe, all RegCs=1, Err=1.
  - Done[winner] = Tick in XFER.
  - On the Tick edge: Gnt clears, the pointer becomes the winner, and state returns to IDLE.
- CLR: RegClr=1 for the whole state. ClearDone = Tick in CLR. Return to IDLE on the Tick edge.
- Output rules:
  - RegWe, RegCs and RegClr are decoded from registered state only; no combinational path from Req/Addr.
  - RegCs is all ones outside a read XFER.
  - RegWe is 0 outside a write XFER.
- Back-to-back access: a requester still holding Req in the IDLE cycle after its Done is treated as a new request. Requesters drop Req the cycle Done is seen.
- Throughput:
  - Minimum 2 Tick cycles per access (IDLE grant + XFER).
  - Under continuous contention the two requesters strictly alternate.

Test Plan:
- Reset=0 mid-XFER (write to reg 3 pending) -> immediately RegWe=0, RegCs=8'hFF, Gnt=0, Busy=0; reg 3 unchanged after Reset=1.
- Req=2'b01, Wr=1, Addr0=5, WData0=8'hA7, Tick=1 every cycle -> Gnt=01 after edge 1, RegWe=8'h20 and BusD=8'hA7 during the next cycle, Done=01 pulse, reg 5 reads back 8'hA7.
- Req=2'b11 held, both writes, for 4 accesses -> grant order 0,1,0,1; Done pulses alternate; never two bits of Gnt set.
- Read Addr1=2 with Tick pulsing every 3rd cycle -> RegCs=8'hFB held across the non-Tick cycles of XFER; Done[1] appears only on the Tick cycle.
- ClearReq=1 and Req=2'b01 rise together in IDLE -> CLR first (RegClr=1, ClearDone pulse), then requester 0 served.
- Addr0=6 with NrOfRegs=6 -> Done[0]=1 with Err=1, RegWe=0, RegCs all ones, no bus drive.
